instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the immediate-extraction path: packs decoded LEGv8 fields (format, opcode, registers, full-width immediate/byte offset) into a 32-bit instruction word.
- Range- and alignment-checks every immediate before packing.
- Writes each valid word sequentially into instruction memory.
- Used by the boot/program-loader path and by testbenches to build program images.

Parameters:
BASE_ADDR, 32'h0040_0000, byte address of the first word written.
DEPTH_WORDS, 256, maximum number of words written before full.
CNT_W, 9, width of oCount; must hold DEPTH_WORDS.

Ports:
iCLK  in  1  clock, rising edge.
iRST_n  in  1  asynchronous active-low reset.
iStart  in  1  synchronous restart: address to BASE_ADDR, count and error cleared, in-flight word aborted.
iValid  in  1  field set valid.
oReady  out  1  block accepts a field set.
iFormat  in  3  0=R, 1=I, 2=D, 3=B, 4=CB; others unsupported.
iOpcode  in  11  opcode, left-aligned as in bits [31:21].
iRd  in  5  Rd/Rt.
iRn  in  5  Rn.
iRm  in  5  Rm (R only).
iShamt  in  6  shamt (R only).
iImm  in  64  I: unsigned value; D: signed offset; B/CB: signed byte offset.
oMemWe  out  1  instruction-memory write strobe.
oMemAddr  out  32  write byte address.
oMemWData  out  32  encoded word.
oCount  out  CNT_W  words written since reset/start.
oFull  out  1  oCount == DEPTH_WORDS.
oError  out  1  sticky fault.
oErrCode  out  2  01 range, 10 misaligned, 11 unsupported format; 00 when no error.

Behaviour:
- Reset (async, iRST_n low): state IDLE, oMemWe=0, oMemWData=0, oMemAddr=BASE_ADDR, oCount=0, oError=0, oErrCode=00. Any in-flight word is dropped.
- oReady = (state==IDLE) & ~oFull & ~oError (combinational).
- FSM states: IDLE, ENC, WRITE, FAULT.
  - IDLE -> ENC on iValid & oReady. All inputs are captured at that edge; later input changes are ignored.
  - ENC: pack and check the captured fields. On the next edge go to WRITE if the check passes, else FAULT.
  - WRITE: oMemWe=1 for exactly this one cycle, with oMemAddr/oMemWData stable. At the edge: oMemAddr += 4, oCount += 1, go to IDLE.
  - FAULT: set oError/oErrCode. Stay in FAULT until iStart.
- Latency: the accept edge is T; oMemWe is high in the cycle between edges T+1 and T+2. Throughput is one word per 3 cycles.
- Packing:
  - R: {op[10:0], Rm, shamt, Rn, Rd}.
  - I: {op[10:1], imm[11:0], Rn, Rd}.
  - D: {op[10:0], imm[8:0], 2'b00, Rn, Rt}.
  - B: {op[10:5], off[27:2]}.
  - CB: {op[10:3], off[20:2], Rt}.
- Checks, in priority order (unsupported > misaligned > range):
  - I: 0 <= iImm <= 4095.
  - D: -256 <= iImm <= 255 (signed 64-bit compare).
  - B: iImm[1:0]==0 and -2^27 <= iImm <= 2^27-4.
  - CB: iImm[1:0]==0 and -2^20 <= iImm <= 2^20-4.
  - R: no check.
- Full: once oCount == DEPTH_WORDS, oFull=1, oReady=0 and iValid is ignored. oMemAddr never wraps.
- iStart: has priority over everything in every state. At the edge: state IDLE, address BASE_ADDR, count 0, error cleared, no write. If iStart and iValid are high together, iStart wins and the field set is not accepted.
- A fault performs no write; address and count are unchanged.

Test Plan:
- ADDI: iFormat=1, iOpcode=11'b10010001000, Rd=1, Rn=2, iImm=5 -> one oMemWe pulse at accept+2 with oMemAddr=0x00400000 and oMemWData=0x91001441; then oCount=1, oMemAddr=0x00400004.
- LDUR then CBZ back-to-back:
  - LDUR: opcode 11111000010, Rt=3, Rn=4, iImm=-8 -> 0xF85F8083 at 0x00400000.
  - CBZ: opcode 10110100xxx, Rt=5, iImm=8 -> 0xB4000045 at 0x00400004.
  - oReady is low for 2 cycles after each accept.
- B: opcode 000101xxxxx, iImm=-4 -> 0x17FFFFFF. Separately, B with iImm=2^27 -> no write, oError=1, oErrCode=01.
- Faults:
  - I-format iImm=4096 -> oErrCode=01, oReady=0 until iStart, oCount unchanged.
  - CB iImm=6 -> 10.
  - iFormat=7 -> 11.
  - After iStart: oError=0, oErrCode=00, oMemAddr=BASE_ADDR.
- Full: DEPTH_WORDS=4; 4 writes to 0x00400000, 0x00400004, 0x00400008, 0x0040000C -> oFull=1, oReady=0; a 5th iValid produces no write. iStart -> oCount=0, oFull=0.
- Reset mid-operation: drop iRST_n asynchronously during ENC -> oMemWe never pulses; outputs at reset values immediately; after release, next word written at 0x00400000.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// LEGv8 instruction encoder / program loader.
// Packs decoded instruction fields into a 32-bit word. Checks the immediate
// for range and alignment. Writes each good word to consecutive
// instruction-memory addresses. A bad field set parks the block in a sticky
// fault until iStart.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          CNT_W       = 9
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic             iValid,
  output logic             oReady,
  input  logic [2:0]       iFormat,
  input  logic [10:0]      iOpcode,
  input  logic [4:0]       iRd,
  input  logic [4:0]       iRn,
  input  logic [4:0]       iRm,
  input  logic [5:0]       iShamt,
  input  logic [63:0]      iImm,
  output logic             oMemWe,
  output logic [31:0]      oMemAddr,
  output logic [31:0]      oMemWData,
  output logic [CNT_W-1:0] oCount,
  output logic             oFull,
  output logic             oError,
  output logic [1:0]       oErrCode
);

  typedef enum logic [1:0] {IDLE, ENC, WRITE, FAULT} state_t;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_D  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_CB = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_FMT   = 2'b11;

  state_t state, state_nx;

  // Field set captured at the accept edge
  logic [2:0]  fmt_q;
  logic [10:0] op_q;
  logic [4:0]  rd_q, rn_q, rm_q;
  logic [5:0]  sh_q;
  logic [63:0] imm_q;

  logic        accept;
  logic [31:0] word_enc;
  logic [1:0]  code_enc;
  logic signed [63:0] simm;

  assign simm   = $signed(imm_q);
  assign oFull  = (oCount == CNT_W'(DEPTH_WORDS));
  assign oReady = (state == IDLE) && !oFull && !oError;
  assign oMemWe = (state == WRITE);
  // iStart outranks a simultaneous iValid
  assign accept = iValid && oReady && !iStart;

  // Pack the captured fields and classify the immediate.
  // Priority: unsupported format, then misalignment, then range.
  always_comb begin
    word_enc = '0;
    code_enc = ERR_NONE;
    case (fmt_q)
      FMT_R: begin
        word_enc = {op_q, rm_q, sh_q, rn_q, rd_q};
      end
      FMT_I: begin
        word_enc = {op_q[10:1], imm_q[11:0], rn_q, rd_q};
        if (imm_q[63:12] != '0) code_enc = ERR_RANGE;
      end
      FMT_D: begin
        word_enc = {op_q, imm_q[8:0], 2'b00, rn_q, rd_q};
        if (simm < -64'sd256 || simm > 64'sd255) code_enc = ERR_RANGE;
      end
      FMT_B: begin
        word_enc = {op_q[10:5], imm_q[27:2]};
        if (imm_q[1:0] != 2'b00)
          code_enc = ERR_ALIGN;
        else if (simm < -64'sd134217728 || simm > 64'sd134217724)
          code_enc = ERR_RANGE;
      end
      FMT_CB: begin
        word_enc = {op_q[10:3], imm_q[20:2], rd_q};
        if (imm_q[1:0] != 2'b00)
          code_enc = ERR_ALIGN;
        else if (simm < -64'sd1048576 || simm > 64'sd1048572)
          code_enc = ERR_RANGE;
      end
      default: begin
        code_enc = ERR_FMT;
      end
    endcase
  end

  // Next-state logic. iStart overrides every state.
  always_comb begin
    state_nx = state;
    if (iStart) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = ENC;
        ENC:     state_nx = (code_enc == ERR_NONE) ? WRITE : FAULT;
        WRITE:   state_nx = IDLE;
        FAULT:   state_nx = FAULT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nx;
  end

  // Field capture, output word, address/count advance and sticky error
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      fmt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      sh_q      <= '0;
      imm_q     <= '0;
      oMemWData <= '0;
      oMemAddr  <= BASE_ADDR;
      oCount    <= '0;
      oError    <= 1'b0;
      oErrCode  <= ERR_NONE;
    end else if (iStart) begin
      oMemAddr <= BASE_ADDR;
      oCount   <= '0;
      oError   <= 1'b0;
      oErrCode <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fmt_q <= iFormat;
            op_q  <= iOpcode;
            rd_q  <= iRd;
            rn_q  <= iRn;
            rm_q  <= iRm;
            sh_q  <= iShamt;
            imm_q <= iImm;
          end
        end
        ENC: begin
          if (code_enc == ERR_NONE) begin
            oMemWData <= word_enc;
          end else begin
            oError   <= 1'b1;
            oErrCode <= code_enc;
          end
        end
        WRITE: begin
          oMemAddr <= oMemAddr + 32'd4;
          oCount   <= oCount + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader. Runs directed cases from the test
// plan, then a randomized field-set sequence. Every result is checked
// against an arithmetic reference encoder.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 4;
  localparam int          CW    = 3;

  logic          iCLK = 1'b0;
  logic          iRST_n = 1'b0;
  logic          iStart = 1'b0;
  logic          iValid = 1'b0;
  logic          oReady;
  logic [2:0]    iFormat = '0;
  logic [10:0]   iOpcode = '0;
  logic [4:0]    iRd = '0, iRn = '0, iRm = '0;
  logic [5:0]    iShamt = '0;
  logic [63:0]   iImm = '0;
  logic          oMemWe;
  logic [31:0]   oMemAddr, oMemWData;
  logic [CW-1:0] oCount;
  logic          oFull, oError;
  logic [1:0]    oErrCode;

  instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iValid(iValid), .oReady(oReady),
    .iFormat(iFormat), .iOpcode(iOpcode), .iRd(iRd), .iRn(iRn), .iRm(iRm),
    .iShamt(iShamt), .iImm(iImm), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .oCount(oCount), .oFull(oFull), .oError(oError),
    .oErrCode(oErrCode)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state
  longint m_addr;
  int     m_count;
  bit     m_err;
  int     m_code;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder, written as plain arithmetic on the field values
  task automatic ref_encode(input int fmt, input longint op, input longint rd,
                            input longint rn, input longint rm, input longint sh,
                            input longint imm, output logic [31:0] w, output int code);
    longint r;
    r = 0;
    code = 0;
    case (fmt)
      0: r = op * (64'sd1 << 21) + rm * (64'sd1 << 16) + sh * 1024 + rn * 32 + rd;
      1: begin
        r = (op / 2) * (64'sd1 << 22) + (imm & 4095) * 1024 + rn * 32 + rd;
        if (imm < 0 || imm > 4095) code = 1;
      end
      2: begin
        r = op * (64'sd1 << 21) + (imm & 511) * 4096 + rn * 32 + rd;
        if (imm < -256 || imm > 255) code = 1;
      end
      3: begin
        r = (op / 32) * (64'sd1 << 26) + ((imm >>> 2) & ((64'sd1 << 26) - 1));
        if (imm % 4 != 0) code = 2;
        else if (imm < -(64'sd1 << 27) || imm > (64'sd1 << 27) - 4) code = 1;
      end
      4: begin
        r = (op / 8) * (64'sd1 << 24) + ((imm >>> 2) & ((64'sd1 << 19) - 1)) * 32 + rd;
        if (imm % 4 != 0) code = 2;
        else if (imm < -(64'sd1 << 20) || imm > (64'sd1 << 20) - 4) code = 1;
      end
      default: code = 3;
    endcase
    w = r[31:0];
  endtask

  task automatic model_clear();
    m_addr = BASE; m_count = 0; m_err = 0; m_code = 0;
  endtask

  // Present one field set at a negedge and follow it for three cycles.
  // Inputs are scrambled after the accept edge, so a design that fails to
  // capture them produces a wrong word.
  task automatic do_op(input int fmt, input logic [10:0] op, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm, input logic [5:0] sh,
                       input longint imm);
    bit exp_ready;
    logic [31:0] w;
    int code;
    exp_ready = !m_err && (m_count < DEPTH);
    chk("ready_pre", oReady, exp_ready);
    iFormat = fmt[2:0]; iOpcode = op; iRd = rd; iRn = rn; iRm = rm; iShamt = sh;
    iImm = imm; iValid = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iValid = 1'b0;
    iFormat = 3'($urandom); iOpcode = 11'($urandom); iRd = 5'($urandom);
    iRn = 5'($urandom); iRm = 5'($urandom); iShamt = 6'($urandom);
    iImm = {$urandom, $urandom};
    if (exp_ready) begin
      ref_encode(fmt, longint'(op), longint'(rd), longint'(rn), longint'(rm),
                 longint'(sh), imm, w, code);
      chk("ready_enc", oReady, 1'b0);
      chk("we_enc", oMemWe, 1'b0);
      @(negedge iCLK);
      chk("ready_wr", oReady, 1'b0);
      if (code == 0) begin
        chk("we_wr", oMemWe, 1'b1);
        chk("addr_wr", oMemAddr, m_addr);
        chk("wdata_wr", oMemWData, w);
        m_addr += 4;
        m_count++;
      end else begin
        chk("we_fault", oMemWe, 1'b0);
        chk("err_fault", oError, 1'b1);
        chk("code_fault", oErrCode, code);
        m_err = 1;
        m_code = code;
      end
    end else begin
      chk("we_ignored", oMemWe, 1'b0);
      @(negedge iCLK);
      chk("we_ignored2", oMemWe, 1'b0);
    end
    @(negedge iCLK);
    chk("we_post", oMemWe, 1'b0);
    chk("count_post", oCount, m_count);
    chk("addr_post", oMemAddr, m_addr);
    chk("full_post", oFull, m_count == DEPTH);
    chk("err_post", oError, m_err);
    chk("code_post", oErrCode, m_code);
    chk("ready_post", oReady, !m_err && (m_count < DEPTH));
  endtask

  // Pulse iStart. Optionally iValid is raised with it, and must lose.
  task automatic start(input bit with_valid);
    iStart = 1'b1;
    iValid = with_valid;
    iFormat = 3'd0; iOpcode = 11'($urandom);
    @(posedge iCLK);
    @(negedge iCLK);
    iStart = 1'b0;
    iValid = 1'b0;
    model_clear();
    chk("st_err", oError, 1'b0);
    chk("st_code", oErrCode, 2'b00);
    chk("st_addr", oMemAddr, BASE);
    chk("st_count", oCount, 0);
    chk("st_full", oFull, 1'b0);
    chk("st_ready", oReady, 1'b1);
    @(negedge iCLK);
    chk("st_we", oMemWe, 1'b0);
    chk("st_ready2", oReady, 1'b1);
  endtask

  function automatic longint pick_imm(input int fmt);
    longint lo, hi, span;
    int s;
    s = $urandom_range(0, 5);
    case (fmt)
      1: begin lo = 0; hi = 4095; end
      2: begin lo = -256; hi = 255; end
      3: begin lo = -(64'sd1 << 27); hi = (64'sd1 << 27) - 4; end
      4: begin lo = -(64'sd1 << 20); hi = (64'sd1 << 20) - 4; end
      default: begin lo = -1000; hi = 1000; end
    endcase
    span = (hi - lo) / 4 + 1;
    case (s)
      0: return lo;
      1: return hi;
      2: return hi + 4;
      3: return lo - 4;
      4: return lo + 4 * (longint'($urandom) % span);
      default: return lo + 4 * (longint'($urandom) % (span - 1)) + 1;
    endcase
  endfunction

  initial begin
    model_clear();
    // Reset values while held in reset
    repeat (2) @(negedge iCLK);
    chk("rst_we", oMemWe, 1'b0);
    chk("rst_wdata", oMemWData, 32'h0);
    chk("rst_addr", oMemAddr, BASE);
    chk("rst_count", oCount, 0);
    chk("rst_err", oError, 1'b0);
    chk("rst_code", oErrCode, 2'b00);
    iRST_n = 1'b1;
    @(negedge iCLK);
    chk("rst_ready", oReady, 1'b1);

    // ADDI X1, X2, #5
    do_op(1, 11'b10010001000, 5'd1, 5'd2, 5'd0, 6'd0, 5);
    chk("addi_word", oMemWData, 32'h9100_1441);

    // LDUR then CBZ back to back
    start(1'b0);
    do_op(2, 11'b11111000010, 5'd3, 5'd4, 5'd0, 6'd0, -8);
    chk("ldur_word", oMemWData, 32'hF85F_8083);
    do_op(4, 11'b10110100000, 5'd5, 5'd0, 5'd0, 6'd0, 8);
    chk("cbz_word", oMemWData, 32'hB400_0045);

    // B -4, then B out of range
    do_op(3, 11'b00010100000, 5'd0, 5'd0, 5'd0, 6'd0, -4);
    chk("b_word", oMemWData, 32'h17FF_FFFF);
    do_op(3, 11'b00010100000, 5'd0, 5'd0, 5'd0, 6'd0, 64'sd134217728);
    do_op(0, 11'h458, 5'd1, 5'd2, 5'd3, 6'd0, 0);  // ignored while faulted

    // Fault codes, each cleared by iStart
    start(1'b0);
    do_op(1, 11'b10010001000, 5'd1, 5'd2, 5'd0, 6'd0, 4096);
    start(1'b0);
    do_op(4, 11'b10110100000, 5'd5, 5'd0, 5'd0, 6'd0, 6);
    start(1'b0);
    do_op(7, 11'h7FF, 5'd1, 5'd1, 5'd1, 6'd1, 0);
    start(1'b1);

    // Fill to DEPTH; one more field set is ignored
    for (int i = 0; i < DEPTH; i++)
      do_op(0, 11'h458, 5'(i), 5'(i + 1), 5'(i + 2), 6'(i), 0);
    do_op(0, 11'h458, 5'd9, 5'd9, 5'd9, 6'd9, 0);
    start(1'b1);

    // Asynchronous reset while a word is in ENC
    do_op(1, 11'b10010001000, 5'd7, 5'd8, 5'd0, 6'd0, 100);
    iFormat = 3'd1; iOpcode = 11'b10010001000; iRd = 5'd1; iRn = 5'd2; iImm = 64'd5;
    iValid = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iValid = 1'b0;
    #2 iRST_n = 1'b0;
    #1;
    chk("amid_we", oMemWe, 1'b0);
    chk("amid_addr", oMemAddr, BASE);
    chk("amid_count", oCount, 0);
    chk("amid_wdata", oMemWData, 32'h0);
    chk("amid_err", oError, 1'b0);
    @(negedge iCLK);
    chk("amid_we2", oMemWe, 1'b0);
    iRST_n = 1'b1;
    model_clear();
    @(negedge iCLK);
    chk("amid_we3", oMemWe, 1'b0);
    do_op(1, 11'b10010001000, 5'd1, 5'd2, 5'd0, 6'd0, 5);
    chk("amid_after", oMemWData, 32'h9100_1441);

    // Randomized field sets
    for (int n = 0; n < 80; n++) begin
      int fmt;
      fmt = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      if ((m_err || m_count == DEPTH) && $urandom_range(0, 3) != 0)
        start(1'($urandom));
      do_op(fmt, 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            6'($urandom), pick_imm(fmt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
